muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits downstream of the register file, beside the ALU, and consumes the two register read ports (rs/rt data). It produces HI/LO for the MFHI/MFLO write-back mux. The control unit stalls the PC while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `start`  in  1  launches an operation; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  WIDTH  multiplicand or dividend.
- `rt_data`  in  WIDTH  multiplier or divisor.
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, ITER, FIX.
- IDLE:
  - `start`=1 latches `op`, |rs|, |rt| and both sign bits, clears `cnt`, and goes to ITER.
  - Magnitudes are taken only for signed ops; unsigned ops use raw values.
  - DIV/DIVU with `rt_data`=0 goes straight to FIX with a div-by-zero flag set.
- ITER runs one bit per cycle for 32 cycles (`cnt` 0..31), then goes to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division. Each step shifts the remainder left one bit, subtracts the divisor, and keeps the result if non-negative, writing the quotient bit.
- FIX:
  - Applies signs: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes HI/LO. Multiply: HI = upper 32 bits, LO = lower 32 bits. Divide: HI = remainder, LO = quotient.
  - Returns to IDLE with `done`=1.
- Div-by-zero result: HI=`rs_data`, LO=32'hFFFFFFFF. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. This falls out of the 32-bit unsigned magnitude path with no special case.
- MTHI/MTLO:
  - Write on the edge when `hi_we`/`lo_we` is high, in IDLE only.
  - Both enables high writes both registers.
  - Ignored while `busy`.
- `start` and any `*_we` together in IDLE: `start` wins and the write is dropped.
- `start` while busy: ignored. No queueing.
- Arithmetic: 64-bit internal accumulator; 33-bit trial subtract for division; all negation is two's complement modulo 2^WIDTH (or 2^64 for the product).

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, `cnt`=0.
- Reset mid-operation aborts immediately; HI/LO are cleared, not preserved.
- Normal operation, with `start` sampled at the end of cycle T:
  - `busy`=1 in cycles T+1..T+33 (32 ITER + 1 FIX).
  - `done`=1 and new `hi`/`lo` visible in cycle T+34.
  - `busy`=0 in cycle T+34, and a new `start` is accepted in T+34.
- Div-by-zero: `busy`=1 in T+1 only; `done` and the result appear in T+2.
- `done` is high for exactly one cycle and never coincides with `busy`.
- HI/LO change only at the FIX→IDLE edge or on an MTHI/MTLO edge.
- `busy` is a registered output, so the control unit can use it directly as a stall.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`);
  - the state enum (IDLE/ITER/FIX);
  - the `ITER_CNT`=32 constant.
- One natural sub-module, `div_step`: a combinational single restoring step (remainder, divisor in; new remainder and quotient bit out). It is instantiated once in the ITER datapath.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` in T+34; `busy` high for exactly 33 cycles.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0. MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIV 5 / 0 → HI=5, LO=0xFFFFFFFF, `done` in T+2.
- MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle. `lo_we` pulsed at T+10 during a MULT → ignored; LO holds the product at T+34. `start` re-pulsed mid-operation → ignored.
- `Reset` asserted at T+15 of a DIV → next cycle `busy`=0, `done`=0, `hi`=`lo`=0, state IDLE. A fresh MULT 6×7 then gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state codes and the iteration count.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ITER = 2'd1;
  localparam state_t FIX  = 2'd2;

  localparam int ITER_CNT = 32;

  // Even op codes are the signed variants, the upper bit selects divide.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// remainder and keep the difference only when it does not go negative.
import muldiv_pkg::*;

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // The shifted remainder is below twice the divisor, so bit WIDTH of the
  // 33-bit difference is set exactly when the subtraction borrows.
  always_comb begin
    trial    = rem_shift - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: shift-add multiply,
// restoring divide, sign fix-up in a final cycle, plus MTHI/MTLO writes.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER_CNT);
  localparam logic [CW-1:0] LAST = CW'(ITER_CNT - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          op_q;
  logic                sign_a;
  logic                sign_b;
  logic                div0;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;
  logic [2*WIDTH-1:0]  acc;

  logic                rs_neg;
  logic                rt_neg;
  logic [WIDTH-1:0]    rs_mag;
  logic [WIDTH-1:0]    rt_mag;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH-1:0]    step_rem;
  logic                step_q;
  logic                res_neg;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo_fix;
  logic [WIDTH-1:0]    rem_fix;
  logic [WIDTH-1:0]    dividend_raw;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    rs_neg       = is_signed_op(op) & rs_data[WIDTH-1];
    rt_neg       = is_signed_op(op) & rt_data[WIDTH-1];
    rs_mag       = rs_neg ? -rs_data : rs_data;
    rt_mag       = rt_neg ? -rt_data : rt_data;
    mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    res_neg      = sign_a ^ sign_b;
    prod_fix     = res_neg ? -acc : acc;
    quo_fix      = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix      = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    dividend_raw = sign_a ? -mag_a : mag_a;
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_shift ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
    .divisor   (mag_b),
    .rem_next  (step_rem),
    .q_bit     (step_q)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0   <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= rs_neg;
            sign_b <= rt_neg;
            mag_a  <= rs_mag;
            mag_b  <= rt_mag;
            cnt    <= '0;
            busy   <= 1'b1;
            acc    <= {{WIDTH{1'b0}}, (is_div_op(op) ? rs_mag : rt_mag)};
            // A zero divisor skips iteration; FIX substitutes the fixed result.
            if (is_div_op(op) && (rt_data == '0)) begin
              div0  <= 1'b1;
              state <= FIX;
            end else begin
              div0  <= 1'b0;
              state <= ITER;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ITER: begin
          acc <= is_div_op(op_q) ? {step_rem, acc[WIDTH-2:0], step_q}
                                 : {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (div0) begin
            hi <= dividend_raw;
            lo <= '1;
          end else if (is_div_op(op_q)) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, busy/done
// timing, MTHI/MTLO interaction and mid-operation reset.
`timescale 1ns/1ps

module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec  = 0;
  int n_miss = 0;
  int done_cyc;
  int busy_cyc;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .Reset   (Reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Launch at the negedge of cycle T; iteration k observes cycle T+k.
  // pulse_cyc injects an lo_we write plus a stray start mid-operation.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int pulse_cyc, input bit we_with_start,
                                output int d_cyc, output int b_cyc);
    d_cyc = -1;
    b_cyc = 0;
    @(negedge clock);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    if (we_with_start) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (busy) b_cyc++;
      if (done && d_cyc < 0) begin
        d_cyc = k;
        check_output("done_busy_excl", {63'd0, busy}, 64'd0);
      end
      if (k == pulse_cyc) begin
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = OP_DIV; rs_data = '0; rt_data = '0;
      end
      if (d_cyc >= 0) break;
    end
    @(negedge clock);
    check_output("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    $display("[TB] muldiv_unit directed test start");
    repeat (2) @(negedge clock);
    check_output("reset_hi",   {32'd0, hi}, 64'd0);
    check_output("reset_lo",   {32'd0, lo}, 64'd0);
    check_output("reset_busy", {63'd0, busy}, 64'd0);
    check_output("reset_done", {63'd0, done}, 64'd0);
    Reset = 1'b0;

    apply_stimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, done_cyc, busy_cyc);
    check_output("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check_output("multu_done_cyc", 64'(done_cyc), 64'd34);
    check_output("multu_busy_cyc", 64'(busy_cyc), 64'd33);

    apply_stimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, done_cyc, busy_cyc);
    check_output("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);

    apply_stimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, done_cyc, busy_cyc);
    check_output("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    apply_stimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, done_cyc, busy_cyc);
    check_output("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check_output("div_done_cyc", 64'(done_cyc), 64'd34);

    apply_stimulus(OP_DIVU, 32'd100, 32'd7, 0, 1'b0, done_cyc, busy_cyc);
    check_output("divu_100_7", {hi, lo}, {32'd2, 32'd14});

    apply_stimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, done_cyc, busy_cyc);
    check_output("div_min_neg1", {hi, lo}, {32'd0, 32'h8000_0000});

    apply_stimulus(OP_DIV, 32'd5, 32'd0, 0, 1'b0, done_cyc, busy_cyc);
    check_output("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    check_output("div0_done_cyc", 64'(done_cyc), 64'd2);
    check_output("div0_busy_cyc", 64'(busy_cyc), 64'd1);

    // MTHI in IDLE lands on the next edge and leaves LO alone.
    @(negedge clock);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clock);
    hi_we = 1'b0;
    check_output("mthi_idle", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});

    @(negedge clock);
    lo_we = 1'b1; wdata = 32'h0000_5678;
    @(negedge clock);
    lo_we = 1'b0;
    check_output("mtlo_idle", {hi, lo}, {32'h0000_1234, 32'h0000_5678});

    apply_stimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0001, 10, 1'b0, done_cyc, busy_cyc);
    check_output("mult_we_ignored", {hi, lo}, {32'h0000_0001, 32'h0001_0000});
    check_output("restart_ignored_cyc", 64'(done_cyc), 64'd34);

    // Reset at T+15 of a divide aborts it and clears HI/LO.
    @(negedge clock);
    op = OP_DIV; rs_data = 32'd100; rt_data = 32'd3; start = 1'b1;
    repeat (15) begin
      @(negedge clock);
      start = 1'b0;
    end
    check_output("div_busy_before_reset", {63'd0, busy}, 64'd1);
    Reset = 1'b1;
    @(negedge clock);
    check_output("abort_busy", {63'd0, busy}, 64'd0);
    check_output("abort_done", {63'd0, done}, 64'd0);
    check_output("abort_hilo", {hi, lo}, 64'd0);
    Reset = 1'b0;
    @(negedge clock);
    check_output("abort_idle", {62'd0, busy, done}, 64'd0);

    apply_stimulus(OP_MULT, 32'd6, 32'd7, 0, 1'b1, done_cyc, busy_cyc);
    check_output("mult_6x7_after_reset", {hi, lo}, 64'd42);
    check_output("mult_6x7_done_cyc", 64'(done_cyc), 64'd34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
